// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states and owner encoding.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Grant selection between fetch and data requesters.
// Build option ARB_RR_EN: round-robin on simultaneous requests (the side not
// granted last wins); otherwise data has fixed priority and 'last' is ignored.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  logic last,
   output logic winner
);

`ifdef ARB_RR_EN
   // Contention goes to the side opposite the previous grant
   always_comb begin
      if (i_req && d_req) begin
         winner = (last == OWN_D) ? OWN_I : OWN_D;
      end else if (d_req) begin
         winner = OWN_D;
      end else begin
         winner = OWN_I;
      end
   end
`else
   logic unused_inputs;
   assign unused_inputs = i_req ^ last;

   // Data always wins; fetch only when data is not requesting
   always_comb begin
      winner = d_req ? OWN_D : OWN_I;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one shared memory port.
// One transaction at a time: IDLE (grant) -> BUSY (wait mem_ready) -> RESP (done pulse).
// Build option ARB_RR_EN: round-robin grant on contention with a last-grant register.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              i_done,
   output logic              d_done,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   state_t            state, state_nx;
   logic              grant, capture, winner, last_grant;
   logic              owner_q, we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;

`ifdef ARB_RR_EN
   logic last_q;

   // Remember which side received the most recent grant
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= OWN_I;
      end else if (grant) begin
         last_q <= winner;
      end
   end

   assign last_grant = last_q;
`else
   assign last_grant = OWN_I;
`endif

   arb_pick u_pick (
      .i_req  (i_req),
      .d_req  (d_req),
      .last   (last_grant),
      .winner (winner)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and per-state output decode
   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      capture  = 1'b0;
      mem_req  = 1'b0;
      i_done   = 1'b0;
      d_done   = 1'b0;
      busy     = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (i_req || d_req) begin
               grant    = 1'b1;
               state_nx = BUSY;
            end
         end
         BUSY: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               capture  = 1'b1;
               state_nx = RESP;
            end
         end
         RESP: begin
            i_done   = (owner_q == OWN_I);
            d_done   = (owner_q == OWN_D);
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Latch the winner's request at grant; these drive the memory port while BUSY
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q <= OWN_I;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (grant) begin
         owner_q <= winner;
         we_q    <= (winner == OWN_D) ? d_we : 1'b0;
         addr_q  <= (winner == OWN_D) ? d_addr : i_addr;
         wdata_q <= (winner == OWN_D) ? d_wdata : '0;
      end
   end

   // Capture memory read data on completion (also for writes; requester ignores it)
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (capture) begin
         rdata_q <= mem_rdata;
      end
   end

   assign owner     = owner_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference model,
// bench-side memory responder with programmable wait states, directed scenarios.
// Honours ARB_RR_EN the same way as the design build.
module tb_mem_port_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;

   logic          clk, reset;
   logic          i_req, d_req, d_we;
   logic [AW-1:0] i_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic          i_done, d_done, mem_req, mem_we, busy, owner;
   logic [DW-1:0] rdata, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic          mem_ready = 1'b0;
   logic [DW-1:0] mem_rdata = '0;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .i_done    (i_done),
      .d_done    (d_done),
      .rdata     (rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .owner     (owner)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one outstanding transaction record plus a pending-completion flag
   bit            m_active, m_resp, m_own, m_we, pick_d;
   logic [AW-1:0] m_addr  = '0;
   logic [DW-1:0] m_wdata = '0;
   logic [DW-1:0] m_rdata = '0;
`ifdef ARB_RR_EN
   bit            m_last;
`endif

   always @(posedge clk) begin
      if (reset) begin
         m_active = 0; m_resp = 0; m_own = 0; m_we = 0;
         m_addr = '0; m_wdata = '0; m_rdata = '0;
`ifdef ARB_RR_EN
         m_last = 0;
`endif
      end else if (m_resp) begin
         m_resp = 0;
      end else if (m_active) begin
         if (mem_ready) begin
            m_rdata  = mem_rdata;
            m_active = 0;
            m_resp   = 1;
         end
      end else if (i_req || d_req) begin
         if (i_req && d_req) begin
`ifdef ARB_RR_EN
            pick_d = !m_last;
`else
            pick_d = 1;
`endif
         end else begin
            pick_d = d_req;
         end
`ifdef ARB_RR_EN
         m_last = pick_d;
`endif
         m_own    = pick_d;
         m_we     = pick_d ? d_we : 1'b0;
         m_addr   = pick_d ? d_addr : i_addr;
         m_wdata  = pick_d ? d_wdata : '0;
         m_active = 1;
      end
   end

   // Per-cycle comparison against the model, plus event counters for the scenarios
   int       n_idone = 0, n_ddone = 0, n_mreq = 0;
   logic [3:0] own_seq = '0;

   always @(negedge clk) begin
      chk("mem_req", mem_req, m_active);
      chk("busy", busy, m_active | m_resp);
      chk("i_done", i_done, m_resp & !m_own);
      chk("d_done", d_done, m_resp & m_own);
      chk("owner", owner, m_own);
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("rdata", rdata, m_rdata);
      if (mem_req) n_mreq++;
      if (i_done) begin n_idone++; own_seq = {own_seq[2:0], 1'b0}; end
      if (d_done) begin n_ddone++; own_seq = {own_seq[2:0], 1'b1}; end
   end

   // Memory responder: ready after wait_target stall cycles; asserts ready outside BUSY too
   int wait_target = 0;
   int wcnt = 0;

   always @(negedge clk) begin
      if (mem_req) begin
         mem_ready = (wcnt >= wait_target);
         wcnt      = mem_ready ? 0 : wcnt + 1;
         mem_rdata = mem_addr ^ 16'hABDD;
      end else begin
         mem_ready = 1'b1;
         wcnt      = 0;
         mem_rdata = 16'hDEAD;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_done(input int budget, output int lat);
      lat = 0;
      while (!(i_done || d_done) && lat < budget) begin
         step();
         lat++;
      end
      if (!(i_done || d_done)) chk("done_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, b_m, b_i, b_d;
      reset = 1; i_req = 0; d_req = 0; d_we = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      step(); step();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_i_done", i_done, 0);
      chk("rst_d_done", d_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      reset = 0;
      step();

      // Single fetch, memory ready immediately
      wait_target = 0; b_m = n_mreq;
      i_req = 1; i_addr = 16'h0010;
      step();
      chk("fetch_mem_req", mem_req, 1);
      chk("fetch_addr", mem_addr, 16'h0010);
      chk("fetch_we", mem_we, 0);
      wait_done(20, lat);
      i_req = 0;
      chk("fetch_latency", lat + 1, 2);
      chk("fetch_i_done", i_done, 1);
      chk("fetch_d_done", d_done, 0);
      chk("fetch_rdata", rdata, 16'hABCD);
      chk("fetch_mreq_cycles", n_mreq - b_m, 1);
      step();

      // Store with four wait states
      wait_target = 4; b_m = n_mreq;
      d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'h1234;
      wait_done(40, lat);
      d_req = 0; d_we = 0;
      chk("store_d_done", d_done, 1);
      chk("store_i_done", i_done, 0);
      chk("store_mreq_cycles", n_mreq - b_m, 5);
      chk("store_latency", lat, 6);
      step();

      // Contention for four transactions, starting from a fresh last-grant state
      reset = 1; step(); reset = 0;
      wait_target = 1; b_i = n_idone; b_d = n_ddone;
      i_req = 1; i_addr = 16'h0040; d_req = 1; d_we = 0; d_addr = 16'h0300;
      for (int k = 0; k < 4; k++) begin
         wait_done(20, lat);
         if (k == 3) begin i_req = 0; d_req = 0; end
         step();
      end
`ifdef ARB_RR_EN
      chk("contend_owner_seq", own_seq, 4'b1010);
`else
      chk("contend_owner_seq", own_seq, 4'b1111);
`endif
      chk("contend_done_count", (n_idone - b_i) + (n_ddone - b_d), 4);

      // Reset during a BUSY wait state abandons the transaction
      wait_target = 1000; b_i = n_idone; b_d = n_ddone;
      d_req = 1; d_we = 1; d_addr = 16'h0400; d_wdata = 16'h5555;
      step(); step(); step();
      chk("midrst_busy_before", busy, 1);
      chk("midrst_mreq_before", mem_req, 1);
      reset = 1; d_req = 0; d_we = 0;
      step();
      reset = 0;
      chk("midrst_mem_req", mem_req, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_d_done", d_done, 0);
      repeat (5) step();
      chk("midrst_no_done", (n_idone - b_i) + (n_ddone - b_d), 0);

      // Fetch request dropped right after grant still completes once
      wait_target = 2; b_i = n_idone;
      i_req = 1; i_addr = 16'h0080;
      step();
      i_req = 0;
      chk("abandon_mem_req", mem_req, 1);
      wait_done(20, lat);
      chk("abandon_i_done", i_done, 1);
      repeat (4) step();
      chk("abandon_done_count", n_idone - b_i, 1);

      // Fetch request held through its done pulse becomes a second transaction
      wait_target = 0; b_i = n_idone;
      i_req = 1; i_addr = 16'h00C0;
      wait_done(20, lat);
      step();
      wait_done(20, lat);
      i_req = 0;
      step(); step();
      chk("held_req_done_count", n_idone - b_i, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
